rnd_draw_queue: RTL and testbench

Reader-side companion to the game's free-running 10-bit random position generator. Watches the generator's output word, captures each new value, rejects values outside a programmable range (and, optionally, values too close to the last accepted one), and buffers accepted values in a small FIFO. The block-spawn logic pulls X positions from it through a valid/ready handshake, so a fresh in-range position is always available without waiting on the generator's update period.

---
 rtl/rnd_draw_queue_pkg.sv | 23 ++
 rtl/rnd_draw_fifo.sv | 83 ++++++++
 rtl/rnd_draw_queue.sv | 122 ++++++++++++
 tb/tb_rnd_draw_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rnd_draw_queue_pkg.sv
// rnd_draw_queue_pkg: constants and types shared by the random-position
// draw queue and its FIFO.
//   POS_W         position word width (generator output width)
//   RANGE_DEFAULT default inclusive upper bound matching the generator range
//   DROP_W        width of the saturating drop counter
//   filt_e        per-cycle outcome of the capture filter
package rnd_draw_queue_pkg;

  localparam int unsigned       POS_W         = 10;
  localparam logic [POS_W-1:0]  RANGE_DEFAULT = 10'h21C;
  localparam int unsigned       DROP_W        = 8;

  typedef enum logic [1:0] {
    FILT_IDLE,
    FILT_PUSH,
    FILT_DROP
  } filt_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/rnd_draw_fifo.sv
// rnd_draw_fifo: synchronous FIFO with occupancy output and simultaneous
// push/pop at any level (including full). Head word and valid are registered;
// dout reads 0 while empty.
//   clk, rst   clock, asynchronous active-high reset
//   flush      synchronous clear; wins over push/pop
//   push, din  write request and data (dropped if full with no pop)
//   ready      consumer accepts head when valid
//   dout       head-of-queue value
//   valid      queue non-empty
//   level      occupancy
//   full       level == DEPTH
module rnd_draw_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [LW-1:0]    level,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_n, wr_n;
  logic [LW-1:0]    lvl_n;
  logic [WIDTH-1:0] head_n;
  logic             do_pop, do_push, valid_n;

  // The head register is loaded with the word that will sit at rd_n after
  // this edge; when the queue drains to zero in the same cycle a push lands,
  // that word is din itself (memory not yet written).
  always_comb begin
    full    = (level == LW'(DEPTH));
    do_pop  = valid & ready;
    do_push = push & (~full | do_pop);
    rd_n    = rd_ptr + PW'(do_pop);
    wr_n    = wr_ptr + PW'(do_push);
    lvl_n   = level + LW'(do_push) - LW'(do_pop);
    valid_n = (lvl_n != '0);
    if (!valid_n)
      head_n = '0;
    else if (do_push && ((level - LW'(do_pop)) == '0))
      head_n = din;
    else
      head_n = mem[rd_n];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      level  <= lvl_n;
      dout   <= head_n;
      valid  <= valid_n;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rnd_draw_queue.sv
// rnd_draw_queue: captures each new word of the free-running random position
// generator, filters out-of-range (and optionally too-close) values, and
// queues accepted positions for the spawn logic via valid/ready.
//   clk, rst    clock, asynchronous active-high reset
//   rnd_in      generator output word
//   range_max   inclusive upper bound for accepted values
//   flush       synchronous clear of queue and capture stage
//   x_ready     consumer accepts head entry
//   x_pos       head value (0 when empty), x_valid queue non-empty
//   level       occupancy, drop_cnt saturating reject/overflow count
// Build option: define RND_DRAW_MIN_SEP_EN to compile in the minimum
// separation filter (MIN_SEP against the last accepted value).
module rnd_draw_queue
  import rnd_draw_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_SEP = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [POS_W-1:0]             rnd_in,
  input  logic [POS_W-1:0]             range_max,
  input  logic                         flush,
  input  logic                         x_ready,
  output logic [POS_W-1:0]             x_pos,
  output logic                         x_valid,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [DROP_W-1:0]            drop_cnt
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MIN_SEP > 1024) begin : g_bad_param
    $error("rnd_draw_queue: DEPTH must be a power of two >= 2, MIN_SEP <= 1024");
  end

  logic [POS_W-1:0] prev, cap;
  logic             cap_v, full, new_sample;
  filt_e            filt;

`ifdef RND_DRAW_MIN_SEP_EN
  logic [POS_W-1:0]        last;
  logic                    have_last;
  logic signed [POS_W:0]   diff;
  logic [POS_W:0]          dist;
  logic                    too_close;

  always_comb begin
    diff      = $signed({1'b0, cap}) - $signed({1'b0, last});
    dist      = diff[POS_W] ? -diff : diff;
    too_close = (32'(dist) < MIN_SEP);
  end
`endif

  always_comb begin
    new_sample = (rnd_in != prev);
    filt       = FILT_IDLE;
    if (cap_v) begin
      if (cap > range_max)
        filt = FILT_DROP;
`ifdef RND_DRAW_MIN_SEP_EN
      else if (have_last && too_close)
        filt = FILT_DROP;
`endif
      else if (full && !(x_valid && x_ready))
        filt = FILT_DROP;
      else
        filt = FILT_PUSH;
    end
  end

  // A sample overtaken by flush is discarded, not counted as a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '1;
      cap      <= '0;
      cap_v    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      prev <= rnd_in;
      if (flush) begin
        cap_v <= 1'b0;
      end else if (new_sample) begin
        cap   <= rnd_in;
        cap_v <= 1'b1;
      end else begin
        cap_v <= 1'b0;
      end
      if (!flush && filt == FILT_DROP)
        drop_cnt <= sat_inc(drop_cnt);
    end
  end

`ifdef RND_DRAW_MIN_SEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last      <= '0;
      have_last <= 1'b0;
    end else if (flush) begin
      have_last <= 1'b0;
    end else if (filt == FILT_PUSH) begin
      last      <= cap;
      have_last <= 1'b1;
    end
  end
`endif

  rnd_draw_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (POS_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (filt == FILT_PUSH),
    .din   (cap),
    .ready (x_ready),
    .dout  (x_pos),
    .valid (x_valid),
    .level (level),
    .full  (full)
  );

endmodule

// File: tb/tb_rnd_draw_queue.sv
module tb_rnd_draw_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MIN_SEP = 40;
  localparam int unsigned LW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    rnd_in;
  logic [9:0]    range_max;
  logic          flush;
  logic          x_ready;
  logic [9:0]    x_pos;
  logic          x_valid;
  logic [LW-1:0] level;
  logic [7:0]    drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard and reference bookkeeping
  int exp_q[$];
  int m_level;
  int m_last;
  bit m_have_last;
  int exp_drop;

  rnd_draw_queue #(.DEPTH(DEPTH), .MIN_SEP(MIN_SEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .rnd_in    (rnd_in),
    .range_max (range_max),
    .flush     (flush),
    .x_ready   (x_ready),
    .x_pos     (x_pos),
    .x_valid   (x_valid),
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit sep_reject(input int v);
`ifdef RND_DRAW_MIN_SEP_EN
    int d;
    d = (v > m_last) ? v - m_last : m_last - v;
    return m_have_last && (d < MIN_SEP);
`else
    return 1'b0;
`endif
  endfunction

  task automatic count_drop();
    exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
  endtask

  // Drive a new generator word (called just after a negedge, no pops pending).
  task automatic feed(input int v);
    rnd_in = 10'(v);
    if (v > int'(range_max) || sep_reject(v) || m_level == DEPTH) begin
      count_drop();
    end else begin
      exp_q.push_back(v);
      m_level++;
      m_last = v;
      m_have_last = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 20;
    x_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      if (x_valid) check({tag, "_pos"}, int'(x_pos), exp_q.pop_front());
      else budget--;
      @(negedge clk);
    end
    x_ready = 1'b0;
    if (budget == 0) check({tag, "_timeout"}, exp_q.size(), 0);
    exp_q.delete();
    m_level = 0;
    check({tag, "_empty_lvl"}, int'(level), 0);
    check({tag, "_empty_vld"}, int'(x_valid), 0);
  endtask

  initial begin
    rst = 1'b1; rnd_in = 10'h3FF; range_max = 10'd540; flush = 1'b0; x_ready = 1'b0;
    m_level = 0; m_last = 0; m_have_last = 1'b0; exp_drop = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_pos",  int'(x_pos), 0);
    check("rst_vld",  int'(x_valid), 0);
    check("rst_lvl",  int'(level), 0);
    check("rst_drop", int'(drop_cnt), 0);

    // Basic capture latency: captured at E, visible after E+1
    feed(100);
    check("lat_vld_early", int'(x_valid), 0);
    @(negedge clk);
    check("lat_vld", int'(x_valid), 1);
    check("lat_pos", int'(x_pos), 100);
    check("lat_lvl", int'(level), 1);
    drain("basic");

    // Range reject
    range_max = 10'd300;
    feed(250); feed(400); feed(299); feed(301);
    @(negedge clk);
    check("range_lvl",  int'(level), 2);
    check("range_drop", int'(drop_cnt), exp_drop);
    drain("range");

    // Overflow, then push+pop while full
    range_max = 10'd540;
    feed(10); feed(60); feed(110); feed(160); feed(210);
    @(negedge clk);
    check("ovf_lvl",  int'(level), 4);
    check("ovf_drop", int'(drop_cnt), exp_drop);
    rnd_in = 10'd260;
    @(negedge clk);
    x_ready = 1'b1;
    check("full_pp_head", int'(x_pos), exp_q.pop_front());
    exp_q.push_back(260);
    m_last = 260; m_have_last = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    check("full_pp_lvl",  int'(level), 4);
    check("full_pp_drop", int'(drop_cnt), exp_drop);
    drain("ovf");

    // Separation filter (all accepted when compiled out)
    feed(100); feed(120); feed(139); feed(141);
    @(negedge clk);
    check("sep_drop", int'(drop_cnt), exp_drop);
    check("sep_lvl",  int'(level), m_level);
    drain("sep");

    // Flush beats a simultaneous push and pop
    feed(300); feed(400); feed(500);
    @(negedge clk);
    check("pre_flush_lvl", int'(level), 3);
    rnd_in = 10'd200;
    @(negedge clk);
    flush = 1'b1; x_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; x_ready = 1'b0;
    exp_q.delete(); m_level = 0; m_have_last = 1'b0;
    check("flush_lvl",  int'(level), 0);
    check("flush_vld",  int'(x_valid), 0);
    check("flush_pos",  int'(x_pos), 0);
    check("flush_drop", int'(drop_cnt), exp_drop);
    feed(495);
    @(negedge clk);
    check("post_flush_lvl", int'(level), 1);
    drain("post_flush");

    // Asynchronous reset between edges
    feed(100); feed(300);
    @(negedge clk);
    check("pre_rst_lvl", int'(level), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_lvl",  int'(level), 0);
    check("arst_vld",  int'(x_valid), 0);
    check("arst_pos",  int'(x_pos), 0);
    check("arst_drop", int'(drop_cnt), 0);
    rnd_in = 10'h3FF;
    exp_q.delete(); m_level = 0; m_have_last = 1'b0; m_last = 0; exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Drop counter saturation
    range_max = 10'd0;
    for (int i = 1; i <= 300; i++) feed(i);
    @(negedge clk);
    check("sat_drop", int'(drop_cnt), exp_drop);
    check("sat_val",  exp_drop, 255);
    check("sat_lvl",  int'(level), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
